// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: op codes, FSM states, lane-select constants.
package mau_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_SW  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_SB  = 3'b110,
    OP_SH  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_MODIFY = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int BYTE_W       = 8;
  localparam int HALF_W       = 16;
  localparam int HALF_SEL_BIT = 1;

  function automatic logic is_word(op_e op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_sub_store(op_e op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

  function automatic logic is_misaligned(op_e op, logic [1:0] lane);
    case (op)
      OP_LH, OP_LHU, OP_SH: return lane[0];
      OP_LW, OP_SW:         return lane != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mau_lane_unit.sv
// Combinational byte/half lane logic: load extract with sign/zero extension and store merge.
module mau_lane_unit
  import mau_pkg::*;
(
  input  op_e         op,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte    = word[{lane, 3'b000} +: BYTE_W];
    sel_half    = word[{lane[HALF_SEL_BIT], 4'b0000} +: HALF_W];
    load_data   = word;
    merged_word = word;
    case (op)
      OP_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU: load_data = {24'h0, sel_byte};
      OP_LH:  load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU: load_data = {16'h0, sel_half};
      OP_SB:  merged_word[{lane, 3'b000} +: BYTE_W] = store_data[7:0];
      OP_SH:  merged_word[{lane[HALF_SEL_BIT], 4'b0000} +: HALF_W] = store_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer with read-modify-write for sub-word stores.
// Optional alignment abort enabled by defining MAU_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ReadData,
  output logic        Misaligned,
  output logic [31:0] DAddr,
  output logic [31:0] MemWData,
  output logic        DataMemRW,
  input  logic [31:0] MemRData
);
  import mau_pkg::*;

  state_e      state, state_nxt;
  op_e         op_q;
  op_e         op_in;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        mis_q;
  logic        mis_req;
  logic [31:0] byte_addr;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign op_in     = op_e'(Op);
  assign byte_addr = Addr + MEM_BASE;

`ifdef MAU_ALIGN_CHECK_EN
  assign mis_req = is_misaligned(op_in, Addr[1:0]);
`else
  assign mis_req = 1'b0;
`endif

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          if (mis_req)              state_nxt = ST_DONE;
          else if (op_in == OP_SW)  state_nxt = ST_WRITE;
          else                      state_nxt = ST_READ;
        end
      end
      ST_READ:   state_nxt = is_sub_store(op_q) ? ST_MODIFY : ST_DONE;
      ST_MODIFY: state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The merged word is registered on entry to MODIFY so it is already
  // stable for the whole cycle before WRITE raises DataMemRW.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      op_q     <= OP_LB;
      lane_q   <= 2'b00;
      wdata_q  <= 16'h0;
      mis_q    <= 1'b0;
      DAddr    <= 32'h0;
      MemWData <= 32'h0;
      ReadData <= 32'h0;
    end else begin
      if (state == ST_IDLE && Start) begin
        op_q    <= op_in;
        lane_q  <= Addr[1:0];
        wdata_q <= WriteData[15:0];
        mis_q   <= mis_req;
        if (!mis_req) begin
          DAddr <= is_word(op_in) ? byte_addr : {byte_addr[31:2], 2'b00};
          if (op_in == OP_SW) MemWData <= WriteData;
        end
      end
      if (state == ST_READ) begin
        if (is_sub_store(op_q)) MemWData <= merged_word;
        else                    ReadData <= load_data;
      end
    end
  end

  mau_lane_unit u_lane (
    .op          (op_q),
    .lane        (lane_q),
    .word        (MemRData),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  assign Busy       = (state != ST_IDLE);
  assign Done       = (state == ST_DONE);
  assign Misaligned = (state == ST_DONE) && mis_q;
  assign DataMemRW  = (state == ST_WRITE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit against a byte-array memory model.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'b000;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic        Busy, Done, Misaligned, DataMemRW;
  logic [31:0] ReadData, DAddr, MemWData, MemRData;

  logic [7:0]  mem [0:1023];
  int          wr_count = 0;
  int          passed = 0;
  int          total = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, SW = 3'b011,
                         LBU = 3'b100, LHU = 3'b101, SB = 3'b110, SH = 3'b111;

  always #5 CLK = ~CLK;

  mem_access_unit dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Op(Op), .Addr(Addr),
    .WriteData(WriteData), .Busy(Busy), .Done(Done), .ReadData(ReadData),
    .Misaligned(Misaligned), .DAddr(DAddr), .MemWData(MemWData),
    .DataMemRW(DataMemRW), .MemRData(MemRData)
  );

  assign MemRData = {mem[DAddr[9:0] + 10'd3], mem[DAddr[9:0] + 10'd2],
                     mem[DAddr[9:0] + 10'd1], mem[DAddr[9:0]]};

  always @(posedge CLK) begin
    if (DataMemRW) begin
      mem[DAddr[9:0]]         <= MemWData[7:0];
      mem[DAddr[9:0] + 10'd1] <= MemWData[15:8];
      mem[DAddr[9:0] + 10'd2] <= MemWData[23:16];
      mem[DAddr[9:0] + 10'd3] <= MemWData[31:24];
      wr_count <= wr_count + 1;
    end
  end

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Issues one request, scrambles the inputs after the start edge, and
  // returns the number of edges from the start edge until Done is seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat);
    @(negedge CLK);
    Op = op; Addr = addr; WriteData = wdata; Start = 1'b1;
    @(posedge CLK); #1;
    Start = 1'b0; Op = ~op; Addr = ~addr; WriteData = ~wdata;
    lat = 1;
    while (!Done && lat < 12) begin
      @(posedge CLK); #1;
      lat++;
    end
    if (!Done) lat = 99;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [0:18];

  initial begin
    int lat, wr0, done_cnt;
    logic [8:0] done_pat;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    {mem[259], mem[258], mem[257], mem[256]} = 32'h8899AABB;

    vecs[0]  = '{LW,  32'h100, 32'h0,        32'h8899AABB, 2, 0, 32'h8899AABB};
    vecs[1]  = '{LB,  32'h103, 32'h0,        32'hFFFFFF88, 2, 0, 32'h8899AABB};
    vecs[2]  = '{LBU, 32'h103, 32'h0,        32'h00000088, 2, 0, 32'h8899AABB};
    vecs[3]  = '{LHU, 32'h102, 32'h0,        32'h00008899, 2, 0, 32'h8899AABB};
    vecs[4]  = '{LH,  32'h100, 32'h0,        32'hFFFFAABB, 2, 0, 32'h8899AABB};
    vecs[5]  = '{LB,  32'h101, 32'h0,        32'hFFFFFFAA, 2, 0, 32'h8899AABB};
    vecs[6]  = '{SB,  32'h101, 32'h12345677, 32'hFFFFFFAA, 4, 1, 32'h889977BB};
    vecs[7]  = '{LW,  32'h100, 32'h0,        32'h889977BB, 2, 0, 32'h889977BB};
    vecs[8]  = '{SH,  32'h102, 32'h0000CAFE, 32'h889977BB, 4, 1, 32'hCAFE77BB};
    vecs[9]  = '{LH,  32'h102, 32'h0,        32'hFFFFCAFE, 2, 0, 32'hCAFE77BB};
    vecs[10] = '{LHU, 32'h100, 32'h0,        32'h000077BB, 2, 0, 32'hCAFE77BB};
    vecs[11] = '{SW,  32'h104, 32'hDEADBEEF, 32'h000077BB, 2, 1, 32'hDEADBEEF};
    vecs[12] = '{LW,  32'h104, 32'h0,        32'hDEADBEEF, 2, 0, 32'hDEADBEEF};
    vecs[13] = '{LB,  32'h104, 32'h0,        32'hFFFFFFEF, 2, 0, 32'hDEADBEEF};
    vecs[14] = '{LBU, 32'h105, 32'h0,        32'h000000BE, 2, 0, 32'hDEADBEEF};
    vecs[15] = '{LB,  32'h107, 32'h0,        32'hFFFFFFDE, 2, 0, 32'hDEADBEEF};
    vecs[16] = '{SB,  32'h107, 32'hFFFFFF01, 32'hFFFFFFDE, 4, 1, 32'h01ADBEEF};
    vecs[17] = '{LW,  32'h104, 32'h0,        32'h01ADBEEF, 2, 0, 32'h01ADBEEF};
    vecs[18] = '{SH,  32'h100, 32'h00001234, 32'h01ADBEEF, 4, 1, 32'hCAFE1234};

    // Reset state
    #12;
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    chk("rst_done", {31'h0, Done}, 32'h0);
    chk("rst_mis", {31'h0, Misaligned}, 32'h0);
    chk("rst_rw", {31'h0, DataMemRW}, 32'h0);
    chk("rst_daddr", DAddr, 32'h0);
    chk("rst_wdata", MemWData, 32'h0);
    chk("rst_rdata", ReadData, 32'h0);
    @(negedge CLK); Reset = 1'b1;

    foreach (vecs[i]) begin
      wr0 = wr_count;
      run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_rdata", i), ReadData, vecs[i].exp_rd);
      chk($sformatf("v%0d_mis", i), {31'h0, Misaligned}, 32'h0);
      chk($sformatf("v%0d_writes", i), wr_count - wr0, vecs[i].exp_wr);
      chk($sformatf("v%0d_word", i), mem_word(vecs[i].addr[9:0] & 10'h3FC), vecs[i].exp_word);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_idle", i), {30'h0, Busy, Done}, 32'h0);
    end

`ifdef MAU_ALIGN_CHECK_EN
    wr0 = wr_count;
    run_op(SW, 32'h102, 32'h55555555, lat);
    chk("mis_sw_lat", lat, 1);
    chk("mis_sw_flag", {31'h0, Misaligned}, 32'h1);
    chk("mis_sw_writes", wr_count - wr0, 0);
    chk("mis_sw_word", mem_word(10'h100), 32'hCAFE1234);
    chk("mis_sw_rdata", ReadData, 32'h01ADBEEF);
    @(posedge CLK); #1;
    run_op(LH, 32'h101, 32'h0, lat);
    chk("mis_lh_lat", lat, 1);
    chk("mis_lh_flag", {31'h0, Misaligned}, 32'h1);
    chk("mis_lh_rdata", ReadData, 32'h01ADBEEF);
    @(posedge CLK); #1;
`else
    // Memory bytes 0x100.. = 34 12 FE CA EF BE AD 01
    run_op(LW, 32'h101, 32'h0, lat);
    chk("ua_lw_lat", lat, 2);
    chk("ua_lw_rdata", ReadData, 32'hEFCAFE12);
    chk("ua_lw_mis", {31'h0, Misaligned}, 32'h0);
    @(posedge CLK); #1;
    run_op(LH, 32'h103, 32'h0, lat);
    chk("ua_lh_rdata", ReadData, 32'hFFFFCAFE);
    @(posedge CLK); #1;
`endif

    // Start held high: a LW completes every 3 cycles and nothing is queued.
    wr0 = wr_count;
    done_pat = '0;
    @(negedge CLK);
    Op = LW; Addr = 32'h104; WriteData = 32'h0; Start = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge CLK); #1;
      done_pat[k] = Done;
    end
    @(negedge CLK); Start = 1'b0;
    done_cnt = 0;
    while (Busy && done_cnt < 10) begin @(posedge CLK); #1; done_cnt++; end
    chk("b2b_done_pattern", {23'h0, done_pat}, 32'h00000092);
    chk("b2b_writes", wr_count - wr0, 0);
    chk("b2b_rdata", ReadData, 32'h01ADBEEF);
    chk("b2b_idle", {31'h0, Busy}, 32'h0);

    // Reset pulled during MODIFY of an SH.
    wr0 = wr_count;
    @(negedge CLK);
    Op = SH; Addr = 32'h106; WriteData = 32'h00009999; Start = 1'b1;
    @(posedge CLK); #1; Start = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b0;
    #1;
    chk("rmid_busy", {31'h0, Busy}, 32'h0);
    chk("rmid_rw", {31'h0, DataMemRW}, 32'h0);
    chk("rmid_done", {31'h0, Done}, 32'h0);
    chk("rmid_daddr", DAddr, 32'h0);
    chk("rmid_rdata", ReadData, 32'h0);
    @(negedge CLK); Reset = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    chk("rmid_writes", wr_count - wr0, 0);
    chk("rmid_word", mem_word(10'h104), 32'h01ADBEEF);
    chk("rmid_idle", {31'h0, Busy}, 32'h0);

    // Unit still functional after the mid-operation reset.
    run_op(LBU, 32'h107, 32'h0, lat);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_rdata", ReadData, 32'h00000001);
    @(posedge CLK); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
